// File: rtl/pcjump_fu.sv
`default_nettype none
// ============================================================================
// Module      : pcjump_fu
// Description : Conditional-jump functional unit. Evaluates a branch condition,
//               buffers the result in a small FIFO and hands it to ROB/CDB.
// Revision    : 1.0 - initial release
// ============================================================================
module pcjump_fu #(
    parameter int WIDTH     = 8,
    parameter int ROBID_W   = 4,
    parameter int DEPTH     = 2,
    parameter int CDB_WRITE = 0,
    parameter int NT_FLAG   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input_transmit,
    input  logic [7:0]           operand,
    input  logic [2*WIDTH-1:0]   depvals,
    input  logic [7:0]           wbs,
    input  logic [7:0]           flags,
    input  logic [ROBID_W-1:0]   robid,
    input  logic                 cdb_transmit,
    output logic                 cdb_transmit_out,
    output logic [ROBID_W-1:0]   cdb_id,
    output logic [WIDTH-1:0]     cdb_val,
    input  logic                 rob_transmit,
    output logic                 rob_transmit_out,
    output logic [ROBID_W-1:0]   robid_out,
    output logic [7:0]           flags_out,
    output logic [7:0]           wbs_out,
    output logic [WIDTH-1:0]     value_out,
    output logic                 busy,
    output logic                 overflow,
    output logic [15:0]          taken_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);

    logic [ROBID_W-1:0] robid_q  [DEPTH];
    logic [7:0]         wbs_q    [DEPTH];
    logic [7:0]         flags_q  [DEPTH];
    logic [WIDTH-1:0]   result_q [DEPTH];
    logic [DEPTH-1:0]   pend_rob_q;
    logic [DEPTH-1:0]   pend_cdb_q;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        taken_q, taken_d;

    logic [WIDTH-1:0]   w_a, w_b, w_result;
    logic [1:0]         w_idx;
    logic [3:0]         w_cond;
    logic               w_take;
    logic [7:0]         w_flags_in;
    logic               w_valid, w_head_rob, w_head_cdb;
    logic               w_rob_acc, w_cdb_acc, w_retire, w_push;
    logic               w_unused_ok;

    assign w_a         = depvals[2*WIDTH-1:WIDTH];
    assign w_b         = depvals[WIDTH-1:0];
    assign w_cond      = operand[3:0];
    assign w_unused_ok = &{1'b0, operand[7:5]};

    // Mode 0 tests a against zero/sign; mode 1 compares a with b (signed)
    always_comb begin
        w_idx    = {w_a[WIDTH-1], |w_a[WIDTH-2:0]};
        w_result = w_b;
        if (operand[4]) begin
            w_idx    = {($signed(w_a) < $signed(w_b)), (w_a != w_b)};
            w_result = w_a;
        end
    end

    assign w_take = w_cond[w_idx];

    always_comb begin
        w_flags_in          = flags;
        w_flags_in[NT_FLAG] = ~w_take;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_valid    = (count_q != '0);
    assign w_head_rob = w_valid & pend_rob_q[rd_ptr_q];
    assign w_head_cdb = w_valid & pend_cdb_q[rd_ptr_q];
    assign w_rob_acc  = rob_transmit & w_head_rob;
    assign w_cdb_acc  = cdb_transmit & w_head_cdb;
    // Head leaves once no request remains outstanding after this edge
    assign w_retire   = w_valid & ~(w_head_rob & ~w_rob_acc) & ~(w_head_cdb & ~w_cdb_acc);
    assign busy       = (count_q == c_DEPTH);
    assign w_push     = input_transmit & ~busy;

    always_comb begin
        count_d    = count_q + CNT_W'(w_push) - CNT_W'(w_retire);
        rd_ptr_d   = w_retire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        overflow_d = overflow_q | (input_transmit & busy);
        taken_d    = taken_q;
        if (w_push && w_take && (taken_q != 16'hFFFF)) begin
            taken_d = taken_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            taken_q    <= '0;
            pend_rob_q <= '0;
            pend_cdb_q <= '0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            taken_q    <= taken_d;
            if (w_rob_acc) pend_rob_q[rd_ptr_q] <= 1'b0;
            if (w_cdb_acc) pend_cdb_q[rd_ptr_q] <= 1'b0;
            if (w_push) begin
                pend_rob_q[wr_ptr_q] <= 1'b1;
                pend_cdb_q[wr_ptr_q] <= (CDB_WRITE != 0);
            end
        end
    end

    // Payload needs no reset: it is only visible while its entry is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            robid_q[wr_ptr_q]  <= robid;
            wbs_q[wr_ptr_q]    <= wbs;
            flags_q[wr_ptr_q]  <= w_flags_in;
            result_q[wr_ptr_q] <= w_result;
        end
    end

    assign rob_transmit_out = w_head_rob;
    assign cdb_transmit_out = w_head_cdb;
    assign robid_out        = w_valid ? robid_q[rd_ptr_q]  : '0;
    assign flags_out        = w_valid ? flags_q[rd_ptr_q]  : '0;
    assign wbs_out          = w_valid ? wbs_q[rd_ptr_q]    : '0;
    assign value_out        = w_valid ? result_q[rd_ptr_q] : '0;
    assign cdb_id           = robid_out;
    assign cdb_val          = value_out;
    assign overflow         = overflow_q;
    assign taken_cnt        = taken_q;

endmodule
`default_nettype wire

// File: tb/tb_pcjump_fu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcjump_fu
// Description : Self-checking bench for pcjump_fu (default and CDB_WRITE=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcjump_fu;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        input_transmit = 1'b0;
    logic [7:0]  operand = '0;
    logic [15:0] depvals = '0;
    logic [7:0]  wbs = '0;
    logic [7:0]  flags = '0;
    logic [3:0]  robid = '0;
    logic        cdb_transmit = 1'b0;
    logic        rob_transmit = 1'b0;

    logic        cdb_out, rob_out, busy, overflow;
    logic [3:0]  cdb_id, robid_out;
    logic [7:0]  cdb_val, flags_out, wbs_out, value_out;
    logic [15:0] taken_cnt;

    logic        c1_cdb_out, c1_rob_out, c1_busy, c1_overflow;
    logic [3:0]  c1_cdb_id, c1_robid_out;
    logic [7:0]  c1_cdb_val, c1_flags_out, c1_wbs_out, c1_value_out;
    logic [15:0] c1_taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pcjump_fu #(.WIDTH(8), .ROBID_W(4), .DEPTH(DEPTH), .CDB_WRITE(0), .NT_FLAG(5)) dut (
        .clk(clk), .rst(rst), .input_transmit(input_transmit), .operand(operand),
        .depvals(depvals), .wbs(wbs), .flags(flags), .robid(robid),
        .cdb_transmit(cdb_transmit), .cdb_transmit_out(cdb_out), .cdb_id(cdb_id),
        .cdb_val(cdb_val), .rob_transmit(rob_transmit), .rob_transmit_out(rob_out),
        .robid_out(robid_out), .flags_out(flags_out), .wbs_out(wbs_out),
        .value_out(value_out), .busy(busy), .overflow(overflow), .taken_cnt(taken_cnt)
    );

    pcjump_fu #(.WIDTH(8), .ROBID_W(4), .DEPTH(DEPTH), .CDB_WRITE(1), .NT_FLAG(5)) dut_cdb (
        .clk(clk), .rst(rst), .input_transmit(input_transmit), .operand(operand),
        .depvals(depvals), .wbs(wbs), .flags(flags), .robid(robid),
        .cdb_transmit(cdb_transmit), .cdb_transmit_out(c1_cdb_out), .cdb_id(c1_cdb_id),
        .cdb_val(c1_cdb_val), .rob_transmit(rob_transmit), .rob_transmit_out(c1_rob_out),
        .robid_out(c1_robid_out), .flags_out(c1_flags_out), .wbs_out(c1_wbs_out),
        .value_out(c1_value_out), .busy(c1_busy), .overflow(c1_overflow),
        .taken_cnt(c1_taken_cnt)
    );

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        input_transmit = 1'b0;
        operand = '0; depvals = '0; wbs = '0; flags = '0; robid = '0;
    endtask

    task automatic issue_set(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] id, input logic [7:0] wb, input logic [7:0] fl);
        input_transmit = 1'b1;
        operand = op; depvals = {a, b}; robid = id; wbs = wb; flags = fl;
    endtask

    task automatic do_reset();
        idle();
        rob_transmit = 1'b0; cdb_transmit = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] robid;
        logic [7:0] wbs;
        logic [7:0] flags;
        logic [7:0] result;
        logic       pr;
        logic       pc;
    } ent_t;

    ent_t mq[$];
    logic        m_ovf;
    int unsigned m_taken;

    // Branch rule straight from the instruction semantics
    function automatic logic ref_take(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        int idx;
        int sa, sb;
        sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        if (op[4] == 1'b0) idx = ((a >= 8'd128) ? 2 : 0) + (((a % 128) != 0) ? 1 : 0);
        else               idx = ((sa < sb) ? 2 : 0) + ((a != b) ? 1 : 0);
        return op[idx];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        n_checks++;
        if ({rob_out, cdb_out, robid_out, flags_out, wbs_out, value_out, cdb_id, cdb_val,
             busy, overflow, taken_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rob=%b busy=%b ovf=%b taken=%h value=%h required all zero",
                     rob_out, busy, overflow, taken_cnt, value_out);
        end
    endtask

    task automatic test_mode0();
        issue_set(8'h04, 8'h80, 8'h5A, 4'd3, 8'h11, 8'hFF);
        cyc();
        idle();
        n_checks++;
        if (rob_out !== 1'b1 || value_out !== 8'h5A || flags_out !== 8'hDF || wbs_out !== 8'h11 ||
            robid_out !== 4'd3 || cdb_out !== 1'b0 || taken_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL mode0_test: got rob=%b val=%h flg=%h wbs=%h id=%h cdb=%b tk=%0d required 1 5a df 11 3 0 1",
                     rob_out, value_out, flags_out, wbs_out, robid_out, cdb_out, taken_cnt);
        end
        rob_transmit = 1'b1;
        cyc();
        rob_transmit = 1'b0;
        n_checks++;
        if (rob_out !== 1'b0 || value_out !== 8'h00 || robid_out !== 4'd0) begin
            n_fail++;
            $display("FAIL mode0_retire: got rob=%b val=%h id=%h required 0 00 0", rob_out, value_out, robid_out);
        end
    endtask

    task automatic test_mode1();
        issue_set(8'h18, 8'hFE, 8'h03, 4'd9, 8'h22, 8'h00);
        cyc();
        idle();
        n_checks++;
        if (rob_out !== 1'b1 || value_out !== 8'hFE || flags_out[5] !== 1'b0 || robid_out !== 4'd9) begin
            n_fail++;
            $display("FAIL mode1_taken: got rob=%b val=%h nt=%b id=%h required 1 fe 0 9",
                     rob_out, value_out, flags_out[5], robid_out);
        end
        rob_transmit = 1'b1;
        cyc();
        rob_transmit = 1'b0;
        issue_set(8'h11, 8'hFE, 8'h03, 4'd10, 8'h22, 8'h00);
        cyc();
        idle();
        n_checks++;
        if (flags_out !== 8'h20 || value_out !== 8'hFE || taken_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL mode1_not_taken: got flg=%h val=%h tk=%0d required 20 fe 2",
                     flags_out, value_out, taken_cnt);
        end
        rob_transmit = 1'b1;
        cyc();
        rob_transmit = 1'b0;
    endtask

    task automatic test_full_overflow();
        issue_set(8'h00, 8'h00, 8'h11, 4'd1, 8'h01, 8'h00);
        cyc();
        n_checks++;
        if (busy !== 1'b0 || robid_out !== 4'd1) begin
            n_fail++;
            $display("FAIL full_one: got busy=%b id=%h required 0 1", busy, robid_out);
        end
        issue_set(8'h00, 8'h00, 8'h12, 4'd2, 8'h02, 8'h00);
        cyc();
        n_checks++;
        if (busy !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_two: got busy=%b ovf=%b required 1 0", busy, overflow);
        end
        issue_set(8'h00, 8'h00, 8'h13, 4'd3, 8'h03, 8'h00);
        cyc();
        idle();
        n_checks++;
        if (overflow !== 1'b1 || busy !== 1'b1 || robid_out !== 4'd1 || value_out !== 8'h11) begin
            n_fail++;
            $display("FAIL full_drop: got ovf=%b busy=%b id=%h val=%h required 1 1 1 11",
                     overflow, busy, robid_out, value_out);
        end
        rob_transmit = 1'b1;
        cyc();
        n_checks++;
        if (robid_out !== 4'd2 || value_out !== 8'h12 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_order: got id=%h val=%h busy=%b required 2 12 0", robid_out, value_out, busy);
        end
        cyc();
        rob_transmit = 1'b0;
        n_checks++;
        if (rob_out !== 1'b0 || robid_out !== 4'd0) begin
            n_fail++;
            $display("FAIL full_drain: got rob=%b id=%h required 0 0", rob_out, robid_out);
        end
    endtask

    task automatic test_full_retire_same_cycle();
        issue_set(8'h00, 8'h00, 8'h44, 4'd4, 8'h00, 8'h00);
        cyc();
        issue_set(8'h00, 8'h00, 8'h55, 4'd5, 8'h00, 8'h00);
        cyc();
        issue_set(8'h00, 8'h00, 8'h66, 4'd6, 8'h00, 8'h00);
        rob_transmit = 1'b1;
        cyc();
        rob_transmit = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || robid_out !== 4'd5) begin
            n_fail++;
            $display("FAIL refuse_on_retire: got busy=%b id=%h required 0 5", busy, robid_out);
        end
        cyc();
        idle();
        n_checks++;
        if (busy !== 1'b1 || robid_out !== 4'd5) begin
            n_fail++;
            $display("FAIL reissue: got busy=%b id=%h required 1 5", busy, robid_out);
        end
        rob_transmit = 1'b1;
        cyc();
        n_checks++;
        if (robid_out !== 4'd6 || value_out !== 8'h66) begin
            n_fail++;
            $display("FAIL reissue_order: got id=%h val=%h required 6 66", robid_out, value_out);
        end
        cyc();
        rob_transmit = 1'b0;
    endtask

    task automatic test_cdb_write();
        do_reset();
        issue_set(8'h0F, 8'h22, 8'h99, 4'd7, 8'h33, 8'h00);
        cyc();
        idle();
        n_checks++;
        if (c1_rob_out !== 1'b1 || c1_cdb_out !== 1'b1 || c1_cdb_id !== 4'd7 || c1_cdb_val !== 8'h99) begin
            n_fail++;
            $display("FAIL cdb_request: got rob=%b cdb=%b id=%h val=%h required 1 1 7 99",
                     c1_rob_out, c1_cdb_out, c1_cdb_id, c1_cdb_val);
        end
        cdb_transmit = 1'b1;
        cyc();
        cdb_transmit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (c1_cdb_out !== 1'b0 || c1_rob_out !== 1'b1 || c1_robid_out !== 4'd7 ||
                c1_value_out !== 8'h99 || c1_wbs_out !== 8'h33 || c1_cdb_id !== 4'd7) begin
                n_fail++;
                $display("FAIL cdb_hold%0d: got cdb=%b rob=%b id=%h val=%h wbs=%h required 0 1 7 99 33",
                         k, c1_cdb_out, c1_rob_out, c1_robid_out, c1_value_out, c1_wbs_out);
            end
            if (k == 0) cyc();
        end
        rob_transmit = 1'b1;
        cyc();
        rob_transmit = 1'b0;
        n_checks++;
        if (c1_rob_out !== 1'b0 || c1_cdb_out !== 1'b0 || c1_robid_out !== 4'd0 || c1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cdb_retire: got rob=%b cdb=%b id=%h busy=%b required 0 0 0 0",
                     c1_rob_out, c1_cdb_out, c1_robid_out, c1_busy);
        end
    endtask

    task automatic test_reset_midflight();
        issue_set(8'h0F, 8'h01, 8'h77, 4'd8, 8'h00, 8'h00);
        cyc();
        issue_set(8'h0F, 8'h01, 8'h78, 4'd9, 8'h00, 8'h00);
        rob_transmit = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rob_transmit = 1'b0;
        idle();
        n_checks++;
        if ({rob_out, robid_out, value_out, busy, overflow, taken_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got rob=%b id=%h val=%h busy=%b ovf=%b tk=%0d required all zero",
                     rob_out, robid_out, value_out, busy, overflow, taken_cnt);
        end
        issue_set(8'h0F, 8'h01, 8'h79, 4'd10, 8'h00, 8'h00);
        cyc();
        idle();
        n_checks++;
        if (rob_out !== 1'b1 || robid_out !== 4'd10 || value_out !== 8'h79 || taken_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_reissue: got rob=%b id=%h val=%h tk=%0d required 1 a 79 1",
                     rob_out, robid_out, value_out, taken_cnt);
        end
    endtask

    task automatic test_random();
        ent_t e, h;
        logic [7:0] a, b;
        logic push, full, tk;
        do_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_taken = 0;
        for (int cyc_i = 0; cyc_i < 400; cyc_i++) begin
            // Compare DUT against model state before this edge
            if (mq.size() > 0) e = mq[0];
            else e = '0;
            n_checks++;
            if (rob_out !== e.pr || cdb_out !== e.pc || robid_out !== e.robid || cdb_id !== e.robid) begin
                n_fail++;
                $display("FAIL rnd_req@%0d: got rob=%b cdb=%b id=%h cid=%h required %b %b %h",
                         cyc_i, rob_out, cdb_out, robid_out, cdb_id, e.pr, e.pc, e.robid);
            end
            n_checks++;
            if (flags_out !== e.flags || wbs_out !== e.wbs || value_out !== e.result || cdb_val !== e.result) begin
                n_fail++;
                $display("FAIL rnd_head@%0d: got flg=%h wbs=%h val=%h cval=%h required %h %h %h",
                         cyc_i, flags_out, wbs_out, value_out, cdb_val, e.flags, e.wbs, e.result);
            end
            n_checks++;
            if (busy !== (mq.size() == DEPTH) || overflow !== m_ovf || taken_cnt !== 16'(m_taken)) begin
                n_fail++;
                $display("FAIL rnd_status@%0d: got busy=%b ovf=%b tk=%0d required %b %b %0d",
                         cyc_i, busy, overflow, taken_cnt, (mq.size() == DEPTH), m_ovf, m_taken);
            end

            a = 8'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: begin a = 8'h80; b = 8'($urandom); end
                2: begin a = 8'h00; b = 8'($urandom); end
                default: b = 8'($urandom);
            endcase
            input_transmit = ($urandom_range(0, 9) < 6);
            rob_transmit   = $urandom_range(0, 1) == 1;
            cdb_transmit   = $urandom_range(0, 1) == 1;
            operand = 8'($urandom); depvals = {a, b};
            wbs = 8'($urandom); flags = 8'($urandom); robid = 4'($urandom);

            full = (mq.size() == DEPTH);
            push = input_transmit && !full;
            if (input_transmit && full) m_ovf = 1'b1;
            if (mq.size() > 0) begin
                h = mq[0];
                if (rob_transmit) h.pr = 1'b0;
                if (cdb_transmit) h.pc = 1'b0;
                if (!h.pr && !h.pc) void'(mq.pop_front());
                else mq[0] = h;
            end
            if (push) begin
                tk = ref_take(operand, a, b);
                e.robid  = robid;
                e.wbs    = wbs;
                e.flags  = flags;
                e.flags[5] = !tk;
                e.result = operand[4] ? a : b;
                e.pr = 1'b1;
                e.pc = 1'b0;
                mq.push_back(e);
                if (tk && m_taken < 65535) m_taken++;
            end
            cyc();
        end
        idle();
        rob_transmit = 1'b0;
        cdb_transmit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_full_overflow();
        test_full_retire_same_cycle();
        test_cdb_write();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcjump_fu.md
PCJUMP_FU -- requirements
Module: pcjump_fu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand/result width in bits (>=2).
REQ-002 SHALL have parameter ROBID_W, default 4, the ROB id width.
REQ-003 SHALL have parameter DEPTH, default 2, the result buffer entries (>=1).
REQ-004 SHALL have parameter CDB_WRITE, default 0, which when set makes every entry also broadcast on the CDB.
REQ-005 SHALL have parameter NT_FLAG, default 5, the flags bit index that carries "not taken".
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port input_transmit, input, 1 bit: issue valid.
REQ-009 SHALL have port operand, input, 8 bits: [3:0] cond mask, [4] mode.
REQ-010 SHALL have port depvals, input, 2xWIDTH: a=depvals[1], b=depvals[0].
REQ-011 SHALL have ports wbs (input, 8), flags (input, 8) and robid (input, ROBID_W): the instruction tags.
REQ-012 SHALL have port cdb_transmit, input, 1 bit: CDB grant.
REQ-013 SHALL have ports cdb_transmit_out (output, 1), cdb_id (output, ROBID_W) and cdb_val (output, WIDTH): the CDB request.
REQ-014 SHALL have port rob_transmit, input, 1 bit: ROB grant.
REQ-015 SHALL have ports rob_transmit_out (output, 1), robid_out (output, ROBID_W), flags_out (output, 8), wbs_out (output, 8) and value_out (output, WIDTH): the ROB request.
REQ-016 SHALL have port busy, output, 1 bit: buffer full, issue not accepted.
REQ-017 SHALL have port overflow, output, 1 bit: sticky, set when an issue is dropped.
REQ-018 SHALL have port taken_cnt, output, 16 bits: saturating count of taken branches.

Function
REQ-019 SHALL, in mode 0 (test), compute idx = {a[WIDTH-1], |a[WIDTH-2:0]} and result = b.
REQ-020 SHALL, in mode 1 (compare), compute idx = {signed a<b, a!=b} and result = a; idx 2'b10 is unreachable in this mode.
REQ-021 SHALL compute take = cond[idx].
REQ-022 SHALL form the stored flags as flags with bit NT_FLAG replaced by !take; all other bits SHALL pass through unchanged.
REQ-023 SHALL hold a FIFO of DEPTH entries; each entry = {robid, wbs, flags, result, pend_rob, pend_cdb}.
REQ-024 SHALL, when input_transmit=1 and busy=0, write an entry at the clock edge with pend_rob=1 and pend_cdb=CDB_WRITE.
REQ-025 SHALL, when input_transmit=1 and busy=1, drop the issue and set overflow; the buffer SHALL be unchanged.
REQ-026 SHALL assert busy combinationally when count==DEPTH; an issue SHALL NOT be accepted against a retirement in the same cycle.
REQ-027 SHALL drive the head entry's fields onto both output groups.
REQ-028 SHALL set rob_transmit_out = valid & pend_rob and cdb_transmit_out = valid & pend_cdb.
REQ-029 SHALL treat cdb_id as the head robid and cdb_val as the head result.
REQ-030 SHALL treat a grant as accepted only when the grant input and the matching *_out are both high in the same cycle; the matching pend bit SHALL clear at that edge.
REQ-031 SHALL retire the head entry when both pend bits are clear after the edge, including when both grants land in the same cycle; the next entry SHALL present on the following cycle.
REQ-032 SHALL allow the CDB and ROB grants in any order; a grant whose *_out is low SHALL be ignored.
REQ-033 SHALL hold all head outputs stable while any request is pending and ungranted.
REQ-034 SHALL have a latency of 1 cycle from an accepted issue into an empty buffer to rob_transmit_out=1.
REQ-035 SHALL force every output field to 0 when the buffer is empty.
REQ-036 SHALL increment taken_cnt on each accepted issue with take=1, saturating at 16'hFFFF.
REQ-037 SHALL handle issue and retirement in the same cycle (not full) with count unchanged and FIFO order preserved.
REQ-038 SHALL wrap the read and write pointers modulo DEPTH, with no ordering loss across the wrap.

Reset
REQ-039 SHALL, on rst=1 at a clock edge, empty the buffer and zero the pointers, overflow and taken_cnt.
REQ-040 SHALL hold all outputs at 0 after reset, including busy=0.
REQ-041 SHALL give reset priority over a simultaneous issue or grant; a reset mid-handshake SHALL discard pending entries.

Verification
REQ-042 SHALL cover: mode 0, a=8'h80, cond=4'b0100 -> idx=2'b10, take=1, flags_out[5]=0, value_out=b, rob_transmit_out=1 one cycle after issue.
REQ-043 SHALL cover: mode 1, a=8'hFE, b=8'h03, cond=4'b1000 -> idx=2'b11 (lt, ne), take=1, value_out=8'hFE; with cond=4'b0001 -> flags_out[5]=1.
REQ-044 SHALL cover: DEPTH=2, three back-to-back issues with no grants -> busy=1 after two, third dropped, overflow=1; grants then retire the two entries in issue order.
REQ-045 SHALL cover: CDB_WRITE=1 with the CDB grant cycle N and the ROB grant cycle N+2 -> cdb_transmit_out falls at N+1, the entry retires after N+2, and outputs are stable meanwhile.
REQ-046 SHALL cover: buffer full, then rob_transmit=1 and input_transmit=1 in the same cycle -> issue refused, count becomes DEPTH-1; a re-issue next cycle is accepted.
REQ-047 SHALL cover: rst asserted while an entry is pending -> all outputs 0 next cycle, taken_cnt=0, and a new issue is accepted normally.
